sevga_cpu_readback: RTL and testbench

- 68000 bus responder that lets the host read VRAM back through a dedicated 64 KB diagnostic window on the card.
- Complements the write snooper: the snooper only copies CPU writes into VRAM; this block answers CPU read cycles from VRAM with nDTACK.
- Shares VRAM with the video fetch and always yields to it.
- Sits beside the snooper in the top level; the top level muxes its VRAM address and strobes.

---
 rtl/sevga_pkg.sv | 28 ++
 rtl/sevga_sync.sv | 34 +++
 rtl/sevga_cpu_readback.sv | 134 +++++++++++++
 tb/tb_sevga_cpu_readback.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sevga_pkg.sv
// sevga_pkg
//   Shared types for the SEVGA card's CPU-side VRAM logic: the read-back FSM
//   state enum, the VRAM word address type and the byte-lane mask type.
//   laneFromStrobes turns the active-low synchronized data strobes into a
//   lane mask.
package sevga_pkg;

  localparam int VRAM_AW = 15;

  typedef logic [VRAM_AW-1:0] vramAddr_t;

  // Bit LANE_HI = upper byte (UDS, chip 0), bit LANE_LO = lower byte (LDS, chip 1).
  typedef logic [1:0] laneMask_t;
  localparam int LANE_HI = 1;
  localparam int LANE_LO = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_HI = 2'd1,
    RD_LO = 2'd2,
    ACK   = 2'd3
  } rbState_t;

  function automatic laneMask_t laneFromStrobes(input logic udsN, input logic ldsN);
    return {~udsN, ~ldsN};
  endfunction

endpackage

// File: rtl/sevga_sync.sv
// sevga_sync
//   Multi-bit, multi-stage synchronizer for asynchronous strobes, clocked on
//   the falling edge of pixClk like the rest of the CPU-side logic.
// Ports:
//   pixClk      in   pixel clock (falling edge active)
//   reset       in   synchronous active-high reset
//   resetValue  in   WIDTH  value every stage takes while reset is high
//   d           in   WIDTH  asynchronous inputs
//   q           out  WIDTH  synchronized outputs (last stage)
module sevga_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             pixClk,
  input  logic             reset,
  input  logic [WIDTH-1:0] resetValue,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(negedge pixClk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= resetValue;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/sevga_cpu_readback.sv
// sevga_cpu_readback
//   68000 bus responder that answers CPU read cycles in a 64 KB diagnostic
//   window from VRAM. Reads one byte per requested lane (upper first), always
//   yielding VRAM to the video fetch, then holds nDTACK until AS negates.
// Ports:
//   pixClk       in   pixel clock, all logic on its falling edge
//   reset        in   synchronous active-high reset
//   cpuAddr      in   23  CPU address [23:1]
//   ncpuAS/UDS/LDS in  asynchronous active-low bus strobes
//   cpuRnW       in   1 = read
//   vidSlotBusy  in   video fetch owns VRAM this cycle
//   vramDataIn   in   8   VRAM read data
//   vramAddr     out  15  VRAM word address
//   nvramOE      out  VRAM read strobe
//   nvramCE0/1   out  high-byte / low-byte chip selects
//   vramReq      out  this block owns the VRAM address and strobes
//   cpuDataOut   out  16  read data to the CPU
//   cpuDataOE    out  CPU data bus driver enable
//   nDTACK       out  data acknowledge
//
// state | meaning
// IDLE  | waiting for a read hit in the window
// RD_HI | reading the upper byte from chip 0
// RD_LO | reading the lower byte from chip 1
// ACK   | driving data and nDTACK until AS negates
module sevga_cpu_readback
  import sevga_pkg::*;
#(
  parameter logic [7:0] WINDOW_BASE   = 8'hF4,
  parameter int         ACCESS_CYCLES = 1,
  parameter int         SYNC_STAGES   = 2
) (
  input  logic               pixClk,
  input  logic               reset,
  input  logic [23:1]        cpuAddr,
  input  logic               ncpuAS,
  input  logic               ncpuUDS,
  input  logic               ncpuLDS,
  input  logic               cpuRnW,
  input  logic               vidSlotBusy,
  input  logic [7:0]         vramDataIn,
  output logic [VRAM_AW-1:0] vramAddr,
  output logic               nvramOE,
  output logic               nvramCE0,
  output logic               nvramCE1,
  output logic               vramReq,
  output logic [15:0]        cpuDataOut,
  output logic               cpuDataOE,
  output logic               nDTACK
);

  localparam logic [1:0] CNT_LOAD = 2'(ACCESS_CYCLES - 1);

  logic [2:0] strobeS;
  logic       asS, udsS, ldsS;

  sevga_sync #(
    .WIDTH (3),
    .STAGES(SYNC_STAGES)
  ) uStrobeSync (
    .pixClk    (pixClk),
    .reset     (reset),
    .resetValue(3'b111),
    .d         ({ncpuAS, ncpuUDS, ncpuLDS}),
    .q         (strobeS)
  );

  assign {asS, udsS, ldsS} = strobeS;

  rbState_t  state;
  logic [1:0] accCnt;   // down-counter, byte done at terminal count zero
  laneMask_t laneReq;
  logic      hit, rdActive, freeCycle, byteDone;

  assign hit = !asS && cpuRnW && (cpuAddr[23:16] == WINDOW_BASE) && (!udsS || !ldsS);

  assign rdActive  = (state == RD_HI) || (state == RD_LO);
  // Strobes also drop as soon as AS negates so an aborted cycle leaves VRAM at once.
  assign freeCycle = rdActive && !asS && !vidSlotBusy;
  assign byteDone  = freeCycle && (accCnt == 2'd0);

  assign vramReq   = rdActive;
  assign nvramOE   = !freeCycle;
  assign nvramCE0  = !(freeCycle && (state == RD_HI) && laneReq[LANE_HI]);
  assign nvramCE1  = !(freeCycle && (state == RD_LO) && laneReq[LANE_LO]);
  assign nDTACK    = (state != ACK);
  assign cpuDataOE = (state == ACK);

  always_ff @(negedge pixClk) begin
    if (reset) begin
      state      <= IDLE;
      accCnt     <= CNT_LOAD;
      laneReq    <= '0;
      vramAddr   <= '0;
      cpuDataOut <= 16'hFFFF;
    end else begin
      unique case (state)
        IDLE: begin
          if (hit) begin
            vramAddr   <= cpuAddr[15:1];
            laneReq    <= laneFromStrobes(udsS, ldsS);
            cpuDataOut <= 16'hFFFF;   // unrequested lane reads back as FF
            accCnt     <= CNT_LOAD;
            state      <= udsS ? RD_LO : RD_HI;
          end
        end
        RD_HI, RD_LO: begin
          if (asS) begin
            accCnt <= CNT_LOAD;
            state  <= IDLE;
          end else if (vidSlotBusy) begin
            accCnt <= CNT_LOAD;       // video stole the slot: restart this byte
          end else if (byteDone) begin
            accCnt <= CNT_LOAD;
            if (state == RD_HI) begin
              cpuDataOut[15:8] <= vramDataIn;
              state            <= laneReq[LANE_LO] ? RD_LO : ACK;
            end else begin
              cpuDataOut[7:0] <= vramDataIn;
              state           <= ACK;
            end
          end else begin
            accCnt <= accCnt - 2'd1;
          end
        end
        ACK: begin
          if (asS) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sevga_cpu_readback.sv
// Bench for sevga_cpu_readback: one instance with 1-cycle VRAM access and one
// with 2-cycle access share the CPU bus; each transaction is scored on one of
// them against a lane/latency model derived from the bus-cycle rules.
module tb_sevga_cpu_readback;

  localparam int         SYNC   = 2;
  localparam logic [7:0] WINDOW = 8'hF4;

  logic        pixClk, reset;
  logic [23:1] cpuAddr;
  logic        ncpuAS, ncpuUDS, ncpuLDS, cpuRnW, vidSlotBusy;

  logic [14:0] vramAddrA, vramAddrB;
  logic        nvramOEA, nvramOEB, nvramCE0A, nvramCE0B, nvramCE1A, nvramCE1B;
  logic        vramReqA, vramReqB, cpuDataOEA, cpuDataOEB, nDTACKA, nDTACKB;
  logic [15:0] cpuDataOutA, cpuDataOutB;
  logic [7:0]  vramDataInA, vramDataInB;

  logic [7:0] chip0 [0:32767];
  logic [7:0] chip1 [0:32767];
  bit         busyAt [64];

  int errors = 0;
  int checks = 0;

  // Sampled view of the DUT currently being scored.
  logic        sDtack, sOE, sCE0, sCE1, sReq, sDataOE;
  logic [15:0] sData;
  logic [14:0] sAddr;

  initial pixClk = 1'b1;
  always #20 pixClk = ~pixClk;

  assign vramDataInA = (!nvramOEA && !nvramCE0A) ? chip0[vramAddrA] :
                       (!nvramOEA && !nvramCE1A) ? chip1[vramAddrA] : 8'h5A;
  assign vramDataInB = (!nvramOEB && !nvramCE0B) ? chip0[vramAddrB] :
                       (!nvramOEB && !nvramCE1B) ? chip1[vramAddrB] : 8'h5A;

  sevga_cpu_readback #(.WINDOW_BASE(WINDOW), .ACCESS_CYCLES(1), .SYNC_STAGES(SYNC)) dutA (
    .pixClk(pixClk), .reset(reset), .cpuAddr(cpuAddr), .ncpuAS(ncpuAS), .ncpuUDS(ncpuUDS),
    .ncpuLDS(ncpuLDS), .cpuRnW(cpuRnW), .vidSlotBusy(vidSlotBusy), .vramDataIn(vramDataInA),
    .vramAddr(vramAddrA), .nvramOE(nvramOEA), .nvramCE0(nvramCE0A), .nvramCE1(nvramCE1A),
    .vramReq(vramReqA), .cpuDataOut(cpuDataOutA), .cpuDataOE(cpuDataOEA), .nDTACK(nDTACKA)
  );

  sevga_cpu_readback #(.WINDOW_BASE(WINDOW), .ACCESS_CYCLES(2), .SYNC_STAGES(SYNC)) dutB (
    .pixClk(pixClk), .reset(reset), .cpuAddr(cpuAddr), .ncpuAS(ncpuAS), .ncpuUDS(ncpuUDS),
    .ncpuLDS(ncpuLDS), .cpuRnW(cpuRnW), .vidSlotBusy(vidSlotBusy), .vramDataIn(vramDataInB),
    .vramAddr(vramAddrB), .nvramOE(nvramOEB), .nvramCE0(nvramCE0B), .nvramCE1(nvramCE1B),
    .vramReq(vramReqB), .cpuDataOut(cpuDataOutB), .cpuDataOE(cpuDataOEB), .nDTACK(nDTACKB)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:1] wordAddr(input logic [23:0] byteAddr);
    return byteAddr[23:1];
  endfunction

  task automatic cyc();
    @(posedge pixClk);
  endtask

  task automatic sample(input int d);
    if (d == 0) begin
      sDtack = nDTACKA; sOE = nvramOEA; sCE0 = nvramCE0A; sCE1 = nvramCE1A;
      sReq = vramReqA; sDataOE = cpuDataOEA; sData = cpuDataOutA; sAddr = vramAddrA;
    end else begin
      sDtack = nDTACKB; sOE = nvramOEB; sCE0 = nvramCE0B; sCE1 = nvramCE1B;
      sReq = vramReqB; sDataOE = cpuDataOEB; sData = cpuDataOutB; sAddr = vramAddrB;
    end
  endtask

  task automatic clearBusy();
    for (int k = 0; k < 64; k++) busyAt[k] = 1'b0;
  endtask

  // One full bus cycle. Cycle k counts bench clocks from the raw AS assertion;
  // busyAt[k] is the video-fetch claim on VRAM in cycle k.
  task automatic doRead(input int d, input logic [23:1] addr, input logic rnw,
                        input logic udsOn, input logic ldsOn, input string tag);
    int          ac, cur, run, ackAt, relAt, lowCnt, viol;
    logic        hitExp, sawReq, gotOE, relOE;
    logic [15:0] expData, gotData;
    logic [14:0] gotAddr;

    ac      = (d == 0) ? 1 : 2;
    hitExp  = rnw && (addr[23:16] == WINDOW) && (udsOn || ldsOn);
    expData = 16'hFFFF;
    cur     = SYNC + 1;   // first read cycle follows the IDLE cycle that sees the hit
    if (udsOn) begin
      run = 0;
      while (run < ac && cur < 60) begin
        run = busyAt[cur] ? 0 : run + 1;
        cur++;
      end
      expData[15:8] = chip0[addr[15:1]];
    end
    if (ldsOn) begin
      run = 0;
      while (run < ac && cur < 60) begin
        run = busyAt[cur] ? 0 : run + 1;
        cur++;
      end
      expData[7:0] = chip1[addr[15:1]];
    end

    cyc();
    cpuAddr = addr; cpuRnW = rnw; ncpuAS = 1'b0; ncpuUDS = !udsOn; ncpuLDS = !ldsOn;
    ackAt = -1; lowCnt = 0; viol = 0; sawReq = 1'b0;
    gotData = '0; gotAddr = '0; gotOE = 1'b0;
    for (int k = 0; k < 40; k++) begin
      vidSlotBusy = busyAt[k];
      #5;
      sample(d);
      if (sReq) sawReq = 1'b1;
      if (!sCE0 && !sCE1) viol++;
      if (!sOE && vidSlotBusy) viol++;
      if (!sCE0 && !udsOn) viol++;
      if (!sCE1 && !ldsOn) viol++;
      if (!sDtack) begin
        if (ackAt < 0) begin
          ackAt = k; gotData = sData; gotAddr = sAddr; gotOE = sDataOE;
        end
        lowCnt++;
      end
      if (ackAt >= 0 && k == ackAt + 2) break;
      if (!hitExp && k == 15) break;
      cyc();
    end
    checkVal($sformatf("%s_strobes", tag), viol, 0);

    if (hitExp) begin
      checkVal($sformatf("%s_latency", tag), ackAt, cur);
      checkVal($sformatf("%s_data", tag), gotData, expData);
      checkVal($sformatf("%s_vaddr", tag), gotAddr, addr[15:1]);
      checkVal($sformatf("%s_dataoe", tag), gotOE, 1'b1);
      checkVal($sformatf("%s_hold", tag), lowCnt, 3);
    end else begin
      checkVal($sformatf("%s_noack", tag), ackAt, -1);
      checkVal($sformatf("%s_noreq", tag), sawReq, 1'b0);
    end

    cyc();
    ncpuAS = 1'b1; ncpuUDS = 1'b1; ncpuLDS = 1'b1; vidSlotBusy = 1'b0;
    relAt = -1; relOE = 1'b1;
    for (int j = 0; j < 10; j++) begin
      #5;
      sample(d);
      if (sDtack && relAt < 0) begin
        relAt = j; relOE = sDataOE;
      end
      cyc();
    end
    if (hitExp) begin
      // AS negation needs SYNC clocks to reach ACK, which leaves one clock later.
      checkVal($sformatf("%s_release", tag), relAt, SYNC + 1);
      checkVal($sformatf("%s_relDataoe", tag), relOE, 1'b0);
    end
  endtask

  task automatic doAbort();
    int   dtackLow;
    logic ce0At3, reqAt4, reqAt5;
    clearBusy();
    cyc();
    cpuAddr = wordAddr(24'hF42468); cpuRnW = 1'b1;
    ncpuAS = 1'b0; ncpuUDS = 1'b0; ncpuLDS = 1'b0;
    dtackLow = 0; ce0At3 = 1'b1; reqAt4 = 1'b0; reqAt5 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k == 2) begin
        ncpuAS = 1'b1; ncpuUDS = 1'b1; ncpuLDS = 1'b1;   // synced AS negates during RD_LO
      end
      #5;
      sample(0);
      if (!sDtack) dtackLow++;
      if (k == 3) ce0At3 = sCE0;
      if (k == 4) reqAt4 = sReq;
      if (k == 5) reqAt5 = sReq;
      cyc();
    end
    checkVal("abort_hiRead", ce0At3, 1'b0);
    checkVal("abort_inRdLo", reqAt4, 1'b1);
    checkVal("abort_idle", reqAt5, 1'b0);
    checkVal("abort_noDtack", dtackLow, 0);
  endtask

  task automatic doResetInAck();
    int ackAt, lateLow;
    clearBusy();
    cyc();
    cpuAddr = wordAddr(24'hF42468); cpuRnW = 1'b1;
    ncpuAS = 1'b0; ncpuUDS = 1'b0; ncpuLDS = 1'b0;
    ackAt = -1;
    for (int k = 0; k < 20; k++) begin
      #5;
      sample(0);
      if (!sDtack) begin
        ackAt = k;
        break;
      end
      cyc();
    end
    checkVal("rst_ackReached", ackAt, SYNC + 3);
    cyc();
    reset = 1'b1; ncpuAS = 1'b1; ncpuUDS = 1'b1; ncpuLDS = 1'b1;
    cyc();
    reset = 1'b0;
    #5;
    sample(0);
    checkVal("rst_dtack", sDtack, 1'b1);
    checkVal("rst_dataoe", sDataOE, 1'b0);
    checkVal("rst_data", sData, 16'hFFFF);
    checkVal("rst_req", sReq, 1'b0);
    checkVal("rst_vaddr", sAddr, 15'h0);
    lateLow = 0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      #5;
      sample(0);
      if (!sDtack || sReq) lateLow++;
    end
    checkVal("rst_quiet", lateLow, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [23:0] ba;
    int          lane, d;
    logic        rnw;

    for (int i = 0; i < 32768; i++) begin
      chip0[i] = 8'($urandom);
      chip1[i] = 8'($urandom);
    end
    chip0[15'h1234] = 8'hA5;
    chip1[15'h1234] = 8'h3C;
    clearBusy();

    reset = 1'b1; cpuAddr = '0; cpuRnW = 1'b1; vidSlotBusy = 1'b0;
    ncpuAS = 1'b1; ncpuUDS = 1'b1; ncpuLDS = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    #5;
    for (int dd = 0; dd < 2; dd++) begin
      sample(dd);
      checkVal($sformatf("reset%0d_dtack", dd), sDtack, 1'b1);
      checkVal($sformatf("reset%0d_dataoe", dd), sDataOE, 1'b0);
      checkVal($sformatf("reset%0d_req", dd), sReq, 1'b0);
      checkVal($sformatf("reset%0d_strobes", dd), {sOE, sCE0, sCE1}, 3'b111);
      checkVal($sformatf("reset%0d_vaddr", dd), sAddr, 15'h0);
      checkVal($sformatf("reset%0d_data", dd), sData, 16'hFFFF);
    end

    doRead(0, wordAddr(24'hF42468), 1'b1, 1'b1, 1'b1, "word");
    doRead(0, wordAddr(24'hF42468), 1'b1, 1'b0, 1'b1, "loByte");
    doRead(0, wordAddr(24'hF42468), 1'b1, 1'b1, 1'b0, "hiByte");

    // Three busy cycles at RD_HI entry, then one pulse in the middle of the restarted byte.
    clearBusy();
    busyAt[3] = 1'b1; busyAt[4] = 1'b1; busyAt[5] = 1'b1; busyAt[7] = 1'b1;
    doRead(1, wordAddr(24'hF42468), 1'b1, 1'b1, 1'b1, "contend");
    clearBusy();
    doRead(1, wordAddr(24'hF42468), 1'b1, 1'b1, 1'b1, "slowWord");

    doRead(0, wordAddr(24'hF42468), 1'b0, 1'b1, 1'b1, "writeMiss");
    doRead(0, wordAddr(24'hF52468), 1'b1, 1'b1, 1'b1, "addrMiss");

    doAbort();
    doRead(0, wordAddr(24'hF42468), 1'b1, 1'b1, 1'b1, "afterAbort");

    for (int n = 0; n < 24; n++) begin
      ba   = {($urandom_range(0, 4) == 0) ? 8'hF5 : 8'hF4, 15'($urandom), 1'b0};
      lane = $urandom_range(0, 3);
      rnw  = ($urandom_range(0, 4) != 0);
      d    = $urandom_range(0, 1);
      clearBusy();
      for (int k = 3; k < 23; k++) busyAt[k] = ($urandom_range(0, 3) == 0);
      doRead(d, wordAddr(ba), rnw, lane[1], lane[0], $sformatf("rnd%0d", n));
    end

    doResetInAck();
    doRead(0, wordAddr(24'hF42468), 1'b1, 1'b1, 1'b1, "afterReset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
